// File: rtl/otp_stream_cipher.sv
// One-time-pad stream cipher with a loadable pad memory and per-word
// fresh tracking; XORs LANE_W bits per cycle, LSB lane first.
module otp_stream_cipher #(
    parameter int DATA_W    = 16,
    parameter int LANE_W    = 4,
    parameter int PAD_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pad_wr_en,
    input  logic [$clog2(PAD_DEPTH)-1:0] pad_wr_addr,
    input  logic [DATA_W-1:0]            pad_wr_data,
    input  logic                         start,
    input  logic                         decrypt,
    input  logic                         passthrough,
    input  logic [DATA_W-1:0]            input_data,
    input  logic [$clog2(PAD_DEPTH)-1:0] pad_idx_in,
    output logic [DATA_W-1:0]            output_data,
    output logic [$clog2(PAD_DEPTH)-1:0] pad_idx_out,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         exhausted
);

    localparam int IDX_W = $clog2(PAD_DEPTH);
    localparam int L     = DATA_W / LANE_W;
    localparam int CNT_W = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XOR,
        S_DONE
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    pad [PAD_DEPTH];
    logic [PAD_DEPTH-1:0] fresh;
    logic [IDX_W-1:0]     enc_ptr;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    key_q;
    logic [DATA_W-1:0]    result;
    logic                 dec_q;
    logic                 pt_q;
    logic                 reject;
    logic [CNT_W-1:0]     lane_cnt;
    logic [LANE_W-1:0]    lane;
    logic                 accept;

    assign lane      = data_q[LANE_W-1:0] ^ key_q[LANE_W-1:0];
    assign exhausted = ~fresh[enc_ptr];
    assign accept    = start && (state == S_IDLE || state == S_DONE);

    // Pad contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (pad_wr_en) begin
            pad[pad_wr_addr] <= pad_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            output_data <= '0;
            pad_idx_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            enc_ptr     <= '0;
            fresh       <= '0;
            data_q      <= '0;
            key_q       <= '0;
            result      <= '0;
            dec_q       <= 1'b0;
            pt_q        <= 1'b0;
            reject      <= 1'b0;
            lane_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: ;
                S_LOAD: begin
                    busy     <= 1'b1;
                    lane_cnt <= '0;
                    reject   <= 1'b0;
                    state    <= S_XOR;
                    if (pt_q) begin
                        key_q <= '0;
                    end else if (dec_q) begin
                        key_q       <= pad[pad_idx_in];
                        pad_idx_out <= pad_idx_in;
                    end else if (fresh[enc_ptr]) begin
                        key_q          <= pad[enc_ptr];
                        fresh[enc_ptr] <= 1'b0;
                        pad_idx_out    <= enc_ptr;
                        enc_ptr        <= enc_ptr + 1'b1;
                    end else begin
                        reject <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_XOR: begin
                    result <= (result >> LANE_W)
                            | (DATA_W'(lane) << (DATA_W - LANE_W));
                    data_q   <= data_q >> LANE_W;
                    key_q    <= key_q >> LANE_W;
                    lane_cnt <= lane_cnt + 1'b1;
                    if (lane_cnt == CNT_W'(L - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    error       <= reject;
                    output_data <= reject ? '0 : result;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A start on the DONE edge is taken directly, giving back-to-back ops.
            if (accept) begin
                data_q <= input_data;
                dec_q  <= decrypt;
                pt_q   <= passthrough;
                state  <= S_LOAD;
            end
            // Refilling a word on the same edge it is consumed keeps it fresh.
            if (pad_wr_en) begin
                fresh[pad_wr_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Directed testbench for otp_stream_cipher with default parameters.
module tb_otp_stream_cipher;

    logic        clk = 1'b0;
    logic        reset;
    logic        pad_wr_en;
    logic [2:0]  pad_wr_addr;
    logic [15:0] pad_wr_data;
    logic        start;
    logic        decrypt;
    logic        passthrough;
    logic [15:0] input_data;
    logic [2:0]  pad_idx_in;
    logic [15:0] output_data;
    logic [2:0]  pad_idx_out;
    logic        busy;
    logic        done;
    logic        error;
    logic        exhausted;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] r_out;
    logic [2:0]  r_idx;
    logic        r_err;
    int          r_lat;
    logic [2:0]  exp_ptr;

    otp_stream_cipher dut (
        .clk        (clk),
        .reset      (reset),
        .pad_wr_en  (pad_wr_en),
        .pad_wr_addr(pad_wr_addr),
        .pad_wr_data(pad_wr_data),
        .start      (start),
        .decrypt    (decrypt),
        .passthrough(passthrough),
        .input_data (input_data),
        .pad_idx_in (pad_idx_in),
        .output_data(output_data),
        .pad_idx_out(pad_idx_out),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .exhausted  (exhausted)
    );

    always #5 clk = ~clk;

    task automatic write_pad(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pad_wr_en   = 1'b1;
        pad_wr_addr = a;
        pad_wr_data = d;
        @(negedge clk);
        pad_wr_en = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] d, input logic dec,
                          input logic pt, input logic [2:0] idx);
        @(negedge clk);
        input_data  = d;
        decrypt     = dec;
        passthrough = pt;
        pad_idx_in  = idx;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        r_lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                r_lat = c;
                break;
            end
        end
        r_out = output_data;
        r_idx = pad_idx_out;
        r_err = error;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({output_data, pad_idx_out} !== 19'h0)
            $display("FAIL reset_data got %h/%h want 0/0", output_data, pad_idx_out);
        else passed++;
        total++;
        if ({done, busy, error, exhausted} !== 4'b0001)
            $display("FAIL reset_flags got %b want 0001",
                     {done, busy, error, exhausted});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_encrypt_decrypt;
        write_pad(3'd0, 16'hA5A5);
        write_pad(3'd1, 16'h0F0F);
        total++;
        if (exhausted !== 1'b0)
            $display("FAIL fresh_after_write got %b want 0", exhausted);
        else passed++;
        run_op(16'h2733, 1'b0, 1'b0, 3'd0);
        total++;
        if (r_out !== 16'h8296) $display("FAIL enc0_out got %h want 8296", r_out);
        else passed++;
        total++;
        if (r_idx !== 3'd0 || r_err !== 1'b0)
            $display("FAIL enc0_idx_err got %0d/%b want 0/0", r_idx, r_err);
        else passed++;
        total++;
        if (r_lat !== 6) $display("FAIL enc0_latency got %0d want 6", r_lat);
        else passed++;
        run_op(16'h8296, 1'b1, 1'b0, 3'd0);
        total++;
        if (r_out !== 16'h2733 || r_lat !== 6)
            $display("FAIL dec0 got %h lat %0d want 2733 lat 6", r_out, r_lat);
        else passed++;
    endtask

    task automatic test_exhaustion;
        run_op(16'h3327, 1'b0, 1'b0, 3'd0);
        total++;
        if (r_out !== 16'h3C28 || r_idx !== 3'd1)
            $display("FAIL enc1 got %h idx %0d want 3c28 idx 1", r_out, r_idx);
        else passed++;
        run_op(16'h0001, 1'b0, 1'b0, 3'd0);
        total++;
        if (r_err !== 1'b1 || r_out !== 16'h0000)
            $display("FAIL reject got err %b out %h want 1 0000", r_err, r_out);
        else passed++;
        total++;
        if (r_lat !== 2) $display("FAIL reject_latency got %0d want 2", r_lat);
        else passed++;
        total++;
        if (r_idx !== 3'd1 || exhausted !== 1'b1)
            $display("FAIL reject_state got idx %0d exh %b want 1 1",
                     r_idx, exhausted);
        else passed++;
    endtask

    task automatic test_passthrough;
        run_op(16'hDEAD, 1'b0, 1'b1, 3'd0);
        total++;
        if (r_out !== 16'hDEAD || r_err !== 1'b0)
            $display("FAIL pass_out got %h err %b want dead 0", r_out, r_err);
        else passed++;
        total++;
        if (r_idx !== 3'd1 || r_lat !== 6)
            $display("FAIL pass_idx_lat got %0d/%0d want 1/6", r_idx, r_lat);
        else passed++;
        write_pad(3'd2, 16'h5555);
        run_op(16'h0000, 1'b0, 1'b0, 3'd0);
        total++;
        if (r_out !== 16'h5555 || r_idx !== 3'd2)
            $display("FAIL ptr_kept got %h idx %0d want 5555 idx 2", r_out, r_idx);
        else passed++;
        exp_ptr = 3'd3;
    endtask

    task automatic test_wrap;
        logic [15:0] pv;
        for (int i = 0; i < 8; i++) begin
            pv = 16'(16'h1111 * (i + 1));
            write_pad(3'(i), pv);
        end
        for (int k = 0; k < 9; k++) begin
            run_op(16'h1234, 1'b0, 1'b0, 3'd0);
            pv = 16'(16'h1111 * (int'(exp_ptr) + 1));
            total++;
            if (k < 8) begin
                if (r_out !== (16'h1234 ^ pv) || r_idx !== exp_ptr || r_err)
                    $display("FAIL wrap_%0d got %h idx %0d err %b want %h idx %0d",
                             k, r_out, r_idx, r_err, 16'h1234 ^ pv, exp_ptr);
                else passed++;
                exp_ptr = exp_ptr + 3'd1;
            end else begin
                if (r_err !== 1'b1 || r_out !== 16'h0)
                    $display("FAIL wrap_reject got err %b out %h want 1 0000",
                             r_err, r_out);
                else passed++;
            end
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        int first;
        logic [15:0] o;
        write_pad(exp_ptr, 16'h00FF);
        @(negedge clk);
        input_data  = 16'h1200;
        decrypt     = 1'b0;
        passthrough = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        first = -1;
        o     = 16'hx;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                input_data = 16'hFFFF;
                start      = 1'b1;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    o     = output_data;
                end
            end
        end
        total++;
        if (ndone !== 1 || first !== 6)
            $display("FAIL ignored_start got %0d dones first %0d want 1 at 6",
                     ndone, first);
        else passed++;
        total++;
        if (o !== 16'h12FF) $display("FAIL ignored_out got %h want 12ff", o);
        else passed++;
        exp_ptr = exp_ptr + 3'd1;
    endtask

    task automatic test_reset_mid;
        int ndone;
        write_pad(exp_ptr, 16'hAAAA);
        @(negedge clk);
        input_data  = 16'h7777;
        decrypt     = 1'b0;
        passthrough = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        total++;
        if (ndone !== 0) $display("FAIL reset_mid_done got %0d want 0", ndone);
        else passed++;
        total++;
        if ({output_data, pad_idx_out, busy, error, exhausted} !== {19'h0, 3'b001})
            $display("FAIL reset_mid_outs got %h %0d %b%b%b want 0 0 001",
                     output_data, pad_idx_out, busy, error, exhausted);
        else passed++;
        exp_ptr = 3'd0;
    endtask

    task automatic test_collision;
        int lat;
        write_pad(3'd0, 16'hABCD);
        @(negedge clk);
        input_data  = 16'h0000;
        decrypt     = 1'b0;
        passthrough = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        pad_wr_en   = 1'b1;
        pad_wr_addr = 3'd0;
        pad_wr_data = 16'h1111;
        @(negedge clk);
        pad_wr_en = 1'b0;
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        total++;
        if (output_data !== 16'hABCD || pad_idx_out !== 3'd0 || lat !== 6)
            $display("FAIL collide_enc got %h idx %0d lat %0d want abcd 0 6",
                     output_data, pad_idx_out, lat);
        else passed++;
        run_op(16'h0000, 1'b1, 1'b0, 3'd0);
        total++;
        if (r_out !== 16'h1111) $display("FAIL collide_new got %h want 1111", r_out);
        else passed++;
        for (int i = 1; i < 8; i++) write_pad(3'(i), 16'h0000);
        for (int i = 1; i < 8; i++) run_op(16'h0000, 1'b0, 1'b0, 3'd0);
        run_op(16'h0000, 1'b0, 1'b0, 3'd0);
        total++;
        if (r_err !== 1'b0 || r_idx !== 3'd0 || r_out !== 16'h1111)
            $display("FAIL collide_fresh got err %b idx %0d out %h want 0 0 1111",
                     r_err, r_idx, r_out);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int c1;
        int c2;
        logic [15:0] o1;
        @(negedge clk);
        input_data  = 16'hCAFE;
        decrypt     = 1'b0;
        passthrough = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        c1 = -1;
        c2 = -1;
        o1 = 16'hx;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (c1 < 0) begin
                    c1    = c;
                    o1    = output_data;
                    start = 1'b0;
                end else begin
                    c2 = c;
                    break;
                end
            end
        end
        start = 1'b0;
        total++;
        if (c1 !== 6 || c2 !== 12)
            $display("FAIL b2b_timing got %0d/%0d want 6/12", c1, c2);
        else passed++;
        total++;
        if (o1 !== 16'hCAFE || output_data !== 16'hCAFE)
            $display("FAIL b2b_out got %h/%h want cafe", o1, output_data);
        else passed++;
    endtask

    initial begin
        pad_wr_en   = 1'b0;
        pad_wr_addr = '0;
        pad_wr_data = '0;
        start       = 1'b0;
        decrypt     = 1'b0;
        passthrough = 1'b0;
        input_data  = '0;
        pad_idx_in  = '0;
        exp_ptr     = '0;
        test_reset();
        test_encrypt_decrypt();
        test_exhaustion();
        test_passthrough();
        test_wrap();
        test_ignored_start();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
